// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROR, at most STEP bits per clock.
// Trades a full barrel shifter for ceil(shamt/STEP) iterations.
module iterative_shifter #(
  parameter int XLEN    = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               kill,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   XLEN_C = (SHAMT_W+1)'(XLEN);

  state_e              state_q, state_d;
  logic [XLEN-1:0]     work_q, work_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [SHAMT_W-1:0]  rem_q, rem_d;
  logic [1:0]          op_q, op_d;
  logic                sign_q, sign_d;

  logic                accept;
  logic                last;
  logic [SHAMT_W-1:0]  k;
  logic [SHAMT_W:0]    k_inv;
  logic [SHAMT_W-1:0]  rem_next;
  logic [XLEN-1:0]     fill;
  logic [XLEN-1:0]     shifted;

  // Start is taken whenever not shifting; kill always wins.
  assign accept = start & ~kill & (state_q != S_SHIFT);

  always_comb begin
    k        = (rem_q < STEP_C) ? rem_q : STEP_C;
    k_inv    = XLEN_C - {1'b0, k};
    rem_next = rem_q - k;
    last     = (rem_next == '0);
    fill     = sign_q ? ~({XLEN{1'b1}} >> k) : '0;
    shifted  = work_q;
    unique case (op_q)
      OP_SLL:  shifted = work_q << k;
      OP_SRL:  shifted = work_q >> k;
      OP_SRA:  shifted = (work_q >> k) | fill;
      OP_ROR:  shifted = (work_q >> k) | (work_q << k_inv);
      default: shifted = work_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (kill) begin
          state_d = S_IDLE;
        end else if (last) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_comb begin
    work_d   = work_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    result_d = result_q;
    if (accept) begin
      work_d = operand;
      rem_d  = shamt;
      op_d   = op;
      sign_d = operand[XLEN-1];
      if (shamt == '0) begin
        result_d = operand;
      end
    end else if ((state_q == S_SHIFT) && !kill) begin
      work_d = shifted;
      rem_d  = rem_next;
      if (last) begin
        result_d = shifted;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work_q   <= '0;
      rem_q    <= '0;
      op_q     <= OP_SLL;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      work_q   <= work_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter: STEP=1 and STEP=4 instances.
// Table-driven vectors plus hand sequences for kill, reset and reissue.
module tb_iterative_shifter;

  logic        clk;
  logic        rst_n;
  logic        kill;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        b1, d1;
  logic [31:0] r1;
  logic        s4_start;
  logic [1:0]  s4_op;
  logic [31:0] s4_opd;
  logic [4:0]  s4_sh;
  logic        b4, d4;
  logic [31:0] r4;

  int total = 0;
  int bad   = 0;

  iterative_shifter #(.XLEN(32), .STEP(1)) u1 (
    .clk(clk), .reset(rst_n), .start(start), .kill(kill),
    .op(op), .operand(operand), .shamt(shamt),
    .busy(b1), .done(d1), .result(r1)
  );

  iterative_shifter #(.XLEN(32), .STEP(4)) u4 (
    .clk(clk), .reset(rst_n), .start(s4_start), .kill(kill),
    .op(s4_op), .operand(s4_opd), .shamt(s4_sh),
    .busy(b4), .done(d4), .result(r4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [31:0] opd;
    logic [4:0]  sh;
    logic [31:0] res;
    int          lat;
    int          nbusy;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge where done is seen.
  task automatic run(input logic sel, input logic [1:0] o,
                     input logic [31:0] d, input logic [4:0] s,
                     output int lat, output int nb,
                     output logic [31:0] r);
    if (sel) begin
      s4_start = 1'b1; s4_op = o; s4_opd = d; s4_sh = s;
    end else begin
      start = 1'b1; op = o; operand = d; shamt = s;
    end
    @(negedge clk);
    start = 1'b0;
    s4_start = 1'b0;
    lat = 1;
    nb = 0;
    while (!(sel ? d4 : d1) && lat < 200) begin
      if (sel ? b4 : b1) nb++;
      @(negedge clk);
      lat++;
    end
    r = sel ? r4 : r1;
  endtask

  int lat, nb, seen;
  logic [31:0] r;

  initial begin
    v[0]  = '{1'b0, 2'b01, 32'd42,        5'd3,  32'd5,        4,  3};
    v[1]  = '{1'b0, 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32, 31};
    v[2]  = '{1'b0, 2'b00, 32'd1,         5'd31, 32'h8000_0000, 32, 31};
    v[3]  = '{1'b0, 2'b10, 32'd1,         5'd1,  32'h8000_0000, 2,  1};
    v[4]  = '{1'b0, 2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  0};
    v[5]  = '{1'b0, 2'b10, 32'h1234_5678, 5'd8,  32'h7812_3456, 9,  8};
    v[6]  = '{1'b0, 2'b11, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 5,  4};
    v[7]  = '{1'b0, 2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 32, 31};
    v[8]  = '{1'b0, 2'b11, 32'hF000_0000, 5'd4,  32'hFF00_0000, 5,  4};
    v[9]  = '{1'b1, 2'b01, 32'h0000_00F0, 5'd5,  32'h0000_0007, 3,  2};
    v[10] = '{1'b1, 2'b00, 32'd1,         5'd31, 32'h8000_0000, 9,  8};
    v[11] = '{1'b1, 2'b10, 32'h0000_00F1, 5'd6,  32'hC400_0003, 3,  2};

    rst_n = 1'b0; kill = 1'b0; start = 1'b0;
    op = '0; operand = '0; shamt = '0;
    s4_start = 1'b0; s4_op = '0; s4_opd = '0; s4_sh = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(b1), 32'd0);
    chk("reset done", 32'(d1), 32'd0);
    chk("reset result", r1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run(v[i].sel, v[i].op, v[i].opd, v[i].sh, lat, nb, r);
      chk($sformatf("vec%0d result", i), r, v[i].res);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("vec%0d busy cycles", i), 32'(nb), 32'(v[i].nbusy));
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i),
          32'(v[i].sel ? d4 : d1), 32'd0);
    end

    // Start held during SHIFT must be ignored.
    start = 1'b1; op = 2'b01; operand = 32'd42; shamt = 5'd3;
    @(negedge clk);
    lat = 1;
    op = 2'b00; operand = 32'hFFFF_FFFF; shamt = 5'd1;
    @(negedge clk);
    lat = 2;
    start = 1'b0;
    while (!d1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore start latency", 32'(lat), 32'd4);
    chk("ignore start result", r1, 32'd5);
    @(negedge clk);
    chk("ignore start idle", 32'({b1, d1}), 32'd0);

    // Kill in the second SHIFT cycle of a shamt=8 op.
    start = 1'b1; op = 2'b00; operand = 32'd1; shamt = 5'd8;
    @(negedge clk);
    start = 1'b0;
    chk("kill pre busy", 32'(b1), 32'd1);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill busy", 32'(b1), 32'd0);
    chk("kill done", 32'(d1), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (d1 || b1) seen++;
    end
    chk("kill no activity", 32'(seen), 32'd0);
    chk("kill result held", r1, 32'd5);

    // Kill together with start in IDLE drops the start.
    start = 1'b1; kill = 1'b1; op = 2'b01; operand = 32'd7; shamt = 5'd0;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill+start done", 32'(d1), 32'd0);
    chk("kill+start result", r1, 32'd5);

    // Back-to-back issue from DONE.
    @(negedge clk);
    run(1'b0, 2'b01, 32'd42, 5'd3, lat, nb, r);
    chk("b2b first result", r, 32'd5);
    run(1'b0, 2'b00, 32'd3, 5'd2, lat, nb, r);
    chk("b2b second latency", 32'(lat), 32'd3);
    chk("b2b second result", r, 32'd12);
    run(1'b0, 2'b00, 32'h0000_ABCD, 5'd0, lat, nb, r);
    chk("b2b zero latency", 32'(lat), 32'd1);
    chk("b2b zero result", r, 32'h0000_ABCD);
    @(negedge clk);
    chk("b2b end done", 32'(d1), 32'd0);

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1; op = 2'b01; operand = 32'h100; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", 32'(b1), 32'd0);
    chk("async done", 32'(d1), 32'd0);
    chk("async result", r1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (d1 || b1) seen++;
    end
    chk("post reset quiet", 32'(seen), 32'd0);
    run(1'b0, 2'b01, 32'h100, 5'd8, lat, nb, r);
    chk("post reset result", r, 32'd1);
    chk("post reset latency", 32'(lat), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Multi-cycle barrel-free shift unit for the RISC-V core's ALU path. It is the parametrised successor to the single-cycle SRLI/SLLI/SRAI shift path.
- Supports SLL, SRL, SRA and ROR with a configurable width and a configurable shift distance per cycle (STEP).
- Trades area for latency. The control FSM issues `start` from EXECUTE/EXECUTEI and stalls until `done`.

Parameters:
- XLEN, 32, operand and result width in bits.
- STEP, 1, maximum bits shifted per cycle. Must be a power of two, 1 <= STEP <= XLEN/2.
- SHAMT_W, $clog2(XLEN), width of the shift amount. Derived; do not override.

Ports:
- clk  input  1  core clock, rising-edge.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- start  input  1  request strobe. Sampled on a rising clk edge when busy=0.
- kill  input  1  synchronous abort of the operation in flight.
- op  input  2  operation code: 00 SLL, 01 SRL, 11 SRA, 10 ROR (rotate right).
- operand  input  XLEN  value to shift. Sampled with start.
- shamt  input  SHAMT_W  shift amount. Sampled with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.
- result  output  XLEN  last completed result. Held until the next completion.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, done=0, result=0, internal work/remaining registers cleared.
  - Reset asserted mid-operation aborts it. No done pulse is produced.
- States: IDLE, SHIFT, DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE, i.e. whenever busy=0.
  - start is ignored while busy=1.
  - On accept, the block captures operand, op and shamt into internal registers.
- Transitions on accept:
  - shamt=0: next state is DONE.
  - shamt!=0: next state is SHIFT, with remaining=shamt.
- SHIFT cycle:
  - k = min(STEP, remaining).
  - SLL: work <<= k, zero-filled.
  - SRL: work >>= k, zero-filled.
  - SRA: work >>= k, filled with the captured operand MSB.
  - ROR: work rotated right by k.
  - remaining -= k. When the new remaining value is 0, next state is DONE.
- Shift-cycle count: ceil(shamt/STEP) SHIFT cycles.
- Latency:
  - done is high in the cycle after the final SHIFT cycle.
  - Total latency = ceil(shamt/STEP)+1 clocks after the accepting edge.
  - shamt=0 gives 1 clock.
- Entering DONE:
  - result <= work (for shamt=0, result <= operand).
  - done=1 for exactly the one cycle spent in DONE.
- Leaving DONE:
  - DONE -> IDLE if start=0.
  - DONE -> SHIFT or DONE if start=1 (back-to-back issue; the done pulse of the previous operation is still seen).
  - result keeps its value until it is overwritten at the next completion.
- kill:
  - In SHIFT: kill=1 forces state to IDLE on the next edge, with no done pulse and result unchanged.
  - kill has priority over start in the same cycle. A kill+start in IDLE/DONE drops the start.
- Shift amounts: shamt is already bounded to XLEN-1 by width. The block does no extra masking and never shifts by XLEN.
- busy: busy = (state==SHIFT). This is a combinational decode of the state register and has no glitch paths from inputs.
- Output timing: all outputs are registered state or a direct state decode. There is no combinational path from start to done.

Test Plan:
- Default params (XLEN=32, STEP=1), operand=42, op=SRL, shamt=3 -> busy high for 3 cycles, done on the 4th cycle after start, result=5.
- op=SRA, operand=0x80000000, shamt=31 -> result=0xFFFFFFFF, latency 32.
- op=SLL, operand=1, shamt=31 -> result=0x80000000.
- op=ROR, operand=0x00000001, shamt=1 -> result=0x80000000.
- shamt=0, operand=0xDEADBEEF -> done 1 cycle after start, result=0xDEADBEEF, busy never asserted.
- STEP=4, op=SRL, operand=0xF0, shamt=5 -> exactly 2 SHIFT cycles, result=0x07.
- Control/abort sequence:
  - 1. Issue start again during SHIFT -> it is ignored and the first result is unaffected.
  - 2. Assert kill at the 2nd SHIFT cycle of shamt=8 -> IDLE, no done, result holds its prior value.
  - 3. Drop reset to 0 mid-SHIFT -> all outputs are 0 immediately.
  - 4. Back-to-back start in DONE -> the second operation completes with the correct latency.
